// File: rtl/snitch_pkg.sv
// Shared Snitch accelerator-interface types: request/response payloads,
// accelerator address map and the requester-index width helper.
package snitch_pkg;

    typedef enum logic [1:0] {
        AccFpSs         = 2'd0,
        AccSharedMulDiv = 2'd1,
        AccDmaSs        = 2'd2,
        AccIpu          = 2'd3
    } acc_addr_e;

    typedef struct packed {
        acc_addr_e   addr;
        logic [4:0]  id;
        logic [31:0] data_op;
        logic [31:0] data_arga;
        logic [31:0] data_argb;
    } acc_req_t;

    typedef struct packed {
        logic [4:0]  id;
        logic        error;
        logic [31:0] data;
    } acc_resp_t;

    // RV32M MUL x0, x0, x0 encoding, used as a representative offloaded op.
    localparam logic [31:0] OpMul = 32'h0200_0033;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? unsigned'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/snitch_route_fifo.sv
// Requester-index FIFO for in-order response routing. Registered output (no
// fall-through); the usage count doubles as the outstanding-request counter.
module snitch_route_fifo #(
    parameter int unsigned Width = 2,
    parameter int unsigned Depth = 4,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  usage_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wptr;
    logic [PtrW-1:0]  r_rptr;
    logic [CntW-1:0]  r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (push_i) r_wptr <= (r_wptr == LastPtr) ? '0 : r_wptr + PtrW'(1);
            if (pop_i)  r_rptr <= (r_rptr == LastPtr) ? '0 : r_rptr + PtrW'(1);
            if (push_i && !pop_i)      r_cnt <= r_cnt + CntW'(1);
            else if (pop_i && !push_i) r_cnt <= r_cnt - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) r_mem[r_wptr] <= data_i;
    end

    assign data_o  = r_mem[r_rptr];
    assign full_o  = (r_cnt == CntW'(Depth));
    assign empty_o = (r_cnt == '0);
    assign usage_o = r_cnt;

endmodule

// File: rtl/snitch_shared_acc_arbiter.sv
// Shares one in-order accelerator among NrCores cores: locked round-robin request
// arbitration with an outstanding limit. SHARED_ACC_PERF_EN adds perf outputs.
module snitch_shared_acc_arbiter
    import snitch_pkg::*;
#(
    parameter int unsigned NrCores        = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned IdxWidth       = idx_width(NrCores)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NrCores-1:0] core_qvalid_i,
    output logic [NrCores-1:0] core_qready_o,
    input  acc_req_t           core_qdata_i [NrCores],
    output logic [NrCores-1:0] core_pvalid_o,
    input  logic [NrCores-1:0] core_pready_i,
    output acc_resp_t          core_pdata_o [NrCores],
    output logic               acc_qvalid_o,
    input  logic               acc_qready_i,
    output acc_req_t           acc_qdata_o,
    input  logic               acc_pvalid_i,
    output logic               acc_pready_o,
    input  acc_resp_t          acc_pdata_i
`ifdef SHARED_ACC_PERF_EN
    ,
    output logic [NrCores-1:0] perf_grant_o,
    output logic               perf_stall_o
`endif
);
    typedef logic [IdxWidth-1:0] idx_t;

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

    logic            r_hold;
    logic            r_lock;
    idx_t            r_lock_idx;
    idx_t            r_rr_ptr;

    logic            w_en;
    logic            w_found;
    logic            w_qvalid;
    logic            w_qhs;
    logic            w_phs;
    logic            w_full;
    logic            w_fifo_full;
    logic            w_empty;
    idx_t            w_k;
    idx_t            w_rr_idx;
    idx_t            w_sel;
    idx_t            w_head;
    logic [CntW-1:0] w_count;

    // Outputs stay quiet during reset and for the first cycle after it.
    assign w_en = !rst_i && !r_hold;

    always_comb begin
        w_found  = 1'b0;
        w_rr_idx = '0;
        w_k      = '0;
        for (int unsigned i = 0; i < NrCores; i++) begin
            w_k = idx_t'((32'(r_rr_ptr) + i) % NrCores);
            if (!w_found && core_qvalid_i[w_k]) begin
                w_found  = 1'b1;
                w_rr_idx = w_k;
            end
        end
    end

    // The full check sees only the registered count, never this cycle's response.
    assign w_full   = (w_count == MaxCnt);
    assign w_sel    = r_lock ? r_lock_idx : w_rr_idx;
    assign w_qvalid = w_en && (r_lock ? core_qvalid_i[r_lock_idx] : (w_found && !w_full));
    assign w_qhs    = w_qvalid && acc_qready_i;

    assign acc_qvalid_o = w_qvalid;
    assign acc_qdata_o  = core_qdata_i[w_sel];

    always_comb begin
        core_qready_o        = '0;
        core_qready_o[w_sel] = w_qhs;
    end

    always_comb begin
        core_pvalid_o         = '0;
        core_pvalid_o[w_head] = acc_pvalid_i && w_en && !w_empty;
        for (int unsigned i = 0; i < NrCores; i++) core_pdata_o[i] = acc_pdata_i;
    end

    assign acc_pready_o = w_en && !w_empty && core_pready_i[w_head];
    assign w_phs        = acc_pvalid_i && acc_pready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hold     <= 1'b1;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_hold <= 1'b0;
            if (w_qhs) begin
                r_lock   <= 1'b0;
                r_rr_ptr <= (w_sel == idx_t'(NrCores - 1)) ? '0 : w_sel + idx_t'(1);
            end else if (w_qvalid) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_sel;
            end
        end
    end

    snitch_route_fifo #(
        .Width (IdxWidth),
        .Depth (MaxOutstanding),
        .CntW  (CntW)
    ) i_route_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_qhs),
        .data_i  (w_sel),
        .pop_i   (w_phs),
        .data_o  (w_head),
        .full_o  (w_fifo_full),
        .empty_o (w_empty),
        .usage_o (w_count)
    );

`ifdef SHARED_ACC_PERF_EN
    assign perf_grant_o = core_qready_o;
    assign perf_stall_o = w_en && (|core_qvalid_i) && !w_qhs;
`endif

`ifndef SYNTHESIS
    resp_without_req: assert property (@(posedge clk_i) disable iff (rst_i)
        !(acc_pvalid_i && w_empty))
        else $error("accelerator response with no request outstanding");
    count_consistent: assert property (@(posedge clk_i) disable iff (rst_i)
        w_fifo_full == (w_count == MaxCnt));
`endif

endmodule

// File: tb/tb_snitch_shared_acc_arbiter.sv
// Randomized and directed self-checking bench for snitch_shared_acc_arbiter against
// a queue-based behavioural model of arbitration, locking and in-order routing.
module tb_snitch_shared_acc_arbiter;
    import snitch_pkg::*;

    localparam int N      = 4;
    localparam int MaxOut = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [N-1:0]  core_qvalid_i;
    logic [N-1:0]  core_qready_o;
    acc_req_t      core_qdata_i [N];
    logic [N-1:0]  core_pvalid_o;
    logic [N-1:0]  core_pready_i;
    acc_resp_t     core_pdata_o [N];
    logic          acc_qvalid_o;
    logic          acc_qready_i;
    acc_req_t      acc_qdata_o;
    logic          acc_pvalid_i;
    logic          acc_pready_o;
    acc_resp_t     acc_pdata_i;
`ifdef SHARED_ACC_PERF_EN
    logic [N-1:0]  perf_grant_o;
    logic          perf_stall_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: in-flight requester order, round-robin start, locked core (-1 = none).
    int m_q[$];
    int m_rr;
    int m_lock;
    bit m_quiet;
    int d_grants[$];
    bit e_qv, e_hsq, e_hsp;
    int e_win;

    always #5 clk = ~clk;

    snitch_shared_acc_arbiter #(
        .NrCores        (N),
        .MaxOutstanding (MaxOut)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .core_qvalid_i (core_qvalid_i),
        .core_qready_o (core_qready_o),
        .core_qdata_i  (core_qdata_i),
        .core_pvalid_o (core_pvalid_o),
        .core_pready_i (core_pready_i),
        .core_pdata_o  (core_pdata_o),
        .acc_qvalid_o  (acc_qvalid_o),
        .acc_qready_i  (acc_qready_i),
        .acc_qdata_o   (acc_qdata_o),
        .acc_pvalid_i  (acc_pvalid_i),
        .acc_pready_o  (acc_pready_o),
        .acc_pdata_i   (acc_pdata_i)
`ifdef SHARED_ACC_PERF_EN
        ,
        .perf_grant_o  (perf_grant_o),
        .perf_stall_o  (perf_stall_o)
`endif
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic acc_req_t rand_req();
        acc_req_t r;
        r.addr      = acc_addr_e'(2'($urandom_range(0, 3)));
        r.id        = 5'($urandom);
        r.data_op   = $urandom;
        r.data_arga = $urandom;
        r.data_argb = $urandom;
        return r;
    endfunction

    function automatic acc_resp_t rand_resp();
        acc_resp_t r;
        r.id    = 5'($urandom);
        r.error = 1'($urandom);
        r.data  = $urandom;
        return r;
    endfunction

    function automatic int pick();
        if (m_lock >= 0) return m_lock;
        if (m_q.size() >= MaxOut) return -1;
        for (int i = 0; i < N; i++) if (core_qvalid_i[(m_rr + i) % N]) return (m_rr + i) % N;
        return -1;
    endfunction

    // Called at the negedge: predicts and compares all outputs for this cycle.
    task automatic eval();
        logic [N-1:0] eqr, epv;
        logic epr, act;
        int head;
        act   = !rst_i && !m_quiet;
        e_win = pick();
        e_qv  = act && (e_win >= 0);
        eqr   = '0;
        if (e_qv && acc_qready_i) eqr[e_win] = 1'b1;
        epv = '0;
        epr = 1'b0;
        head = -1;
        if (act && m_q.size() > 0) begin
            head      = m_q[0];
            epv[head] = acc_pvalid_i;
            epr       = core_pready_i[head];
        end
        e_hsq = e_qv && acc_qready_i;
        e_hsp = acc_pvalid_i && epr;
        check_eq("acc_qvalid", 128'(acc_qvalid_o), 128'(e_qv));
        check_eq("core_qready", 128'(core_qready_o), 128'(eqr));
        if (e_qv) check_eq("acc_qdata", 128'(acc_qdata_o), 128'(core_qdata_i[e_win]));
        check_eq("core_pvalid", 128'(core_pvalid_o), 128'(epv));
        check_eq("acc_pready", 128'(acc_pready_o), 128'(epr));
        if (epv != '0) check_eq("core_pdata", 128'(core_pdata_o[head]), 128'(acc_pdata_i));
`ifdef SHARED_ACC_PERF_EN
        check_eq("perf_grant", 128'(perf_grant_o), 128'(eqr));
        check_eq("perf_stall", 128'(perf_stall_o), 128'(act && (|core_qvalid_i) && !e_hsq));
`endif
        for (int i = 0; i < N; i++) if (core_qready_o[i]) d_grants.push_back(i);
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst_i) begin
            m_q.delete();
            m_rr    = 0;
            m_lock  = -1;
            m_quiet = 1'b1;
        end else begin
            m_quiet = 1'b0;
            if (e_hsp) void'(m_q.pop_front());
            if (e_hsq) begin
                m_q.push_back(e_win);
                m_rr   = (e_win + 1) % N;
                m_lock = -1;
            end else if (e_qv) begin
                m_lock = e_win;
            end
        end
        #1;
        if (!rst_i && e_hsq) core_qvalid_i[e_win] = 1'b0;
        if (!rst_i && e_hsp) acc_pvalid_i = 1'b0;
    endtask

    task automatic cyc();
        @(negedge clk);
        eval();
        advance();
    endtask

    // Core requests are left as they are so output gating through reset is exercised.
    task automatic do_reset();
        rst_i        = 1'b1;
        acc_pvalid_i = 1'b0;
        @(negedge clk);
        eval();
        check_eq("rst_outs", 128'({acc_qvalid_o, acc_pready_o, core_qready_o, core_pvalid_o}), '0);
        advance();
        rst_i = 1'b0;
        @(negedge clk);
        eval();
        check_eq("post_rst_outs",
                 128'({acc_qvalid_o, acc_pready_o, core_qready_o, core_pvalid_o}), '0);
        advance();
    endtask

    task automatic refill();
        for (int i = 0; i < N; i++) begin
            if (!core_qvalid_i[i]) begin
                core_qdata_i[i]  = rand_req();
                core_qvalid_i[i] = 1'b1;
            end
        end
    endtask

    initial begin
        int exp_rr[6];
        int exp_lk[3];
        rst_i         = 1'b1;
        core_qvalid_i = '0;
        core_pready_i = '0;
        acc_qready_i  = 1'b0;
        acc_pvalid_i  = 1'b0;
        acc_pdata_i   = '0;
        for (int i = 0; i < N; i++) core_qdata_i[i] = rand_req();
        m_rr = 0; m_lock = -1; m_quiet = 1'b1;

        // Single request from core 2, response three cycles later.
        do_reset();
        d_grants.delete();
        core_qdata_i[2]         = rand_req();
        core_qdata_i[2].addr    = AccSharedMulDiv;
        core_qdata_i[2].data_op = OpMul;
        core_qvalid_i[2] = 1'b1;
        acc_qready_i     = 1'b1;
        core_pready_i    = '1;
        @(negedge clk);
        eval();
        check_eq("t1_qvalid", 128'(acc_qvalid_o), 128'(1));
        check_eq("t1_qdata_op", 128'(acc_qdata_o.data_op), 128'(OpMul));
        advance();
        acc_qready_i = 1'b0;
        cyc();
        cyc();
        acc_pvalid_i = 1'b1;
        acc_pdata_i  = rand_resp();
        @(negedge clk);
        eval();
        check_eq("t1_pvalid", 128'(core_pvalid_o), 128'(4'b0100));
        check_eq("t1_pdata", 128'(core_pdata_o[2]), 128'(acc_pdata_i));
        advance();
        check_eq("t1_grant_core", 128'(d_grants.size() > 0 ? d_grants[0] : -1), 128'(2));

        // Round robin with all cores requesting and immediate responses.
        core_qvalid_i = '0;
        do_reset();
        d_grants.delete();
        acc_qready_i = 1'b1;
        exp_rr = '{0, 1, 2, 3, 0, 1};
        for (int c = 0; c < 6; c++) begin
            refill();
            acc_pvalid_i = (m_q.size() > 0);
            acc_pdata_i  = rand_resp();
            cyc();
        end
        check_eq("t2_grant_count", 128'(d_grants.size()), 128'(6));
        for (int i = 0; i < 6 && i < d_grants.size(); i++)
            check_eq("t2_rr_order", 128'(d_grants[i]), 128'(exp_rr[i]));

        // Lock: core 1 stalls under back-pressure while core 0 waits behind it.
        core_qvalid_i = '0;
        do_reset();
        d_grants.delete();
        core_pready_i    = '0;
        acc_qready_i     = 1'b0;
        core_qdata_i[1]  = rand_req();
        core_qvalid_i[1] = 1'b1;
        cyc();
        core_qdata_i[0]  = rand_req();
        core_qvalid_i[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            eval();
            check_eq("t3_lock_data", 128'(acc_qdata_o), 128'(core_qdata_i[1]));
            advance();
        end
        core_qdata_i[3]  = rand_req();
        core_qvalid_i[3] = 1'b1;
        acc_qready_i     = 1'b1;
        cyc();
        cyc();
        cyc();
        exp_lk = '{1, 3, 0};
        check_eq("t3_grant_count", 128'(d_grants.size()), 128'(3));
        for (int i = 0; i < 3 && i < d_grants.size(); i++)
            check_eq("t3_lock_order", 128'(d_grants[i]), 128'(exp_lk[i]));

        // Outstanding limit with no responses, then one response reopens the next cycle.
        core_qvalid_i = '0;
        do_reset();
        d_grants.delete();
        acc_qready_i  = 1'b1;
        core_pready_i = '1;
        for (int c = 0; c < 8; c++) begin
            refill();
            cyc();
        end
        check_eq("t4_handshakes", 128'(d_grants.size()), 128'(MaxOut));
        refill();
        acc_pvalid_i = 1'b1;
        acc_pdata_i  = rand_resp();
        @(negedge clk);
        eval();
        check_eq("t4_same_cycle_blocked", 128'(acc_qvalid_o), 128'(0));
        advance();
        refill();
        @(negedge clk);
        eval();
        check_eq("t4_next_cycle_grant", 128'(acc_qvalid_o), 128'(1));
        advance();

        // Response back-pressure from head core 3.
        core_qvalid_i = '0;
        do_reset();
        acc_qready_i     = 1'b1;
        core_qdata_i[3]  = rand_req();
        core_qvalid_i[3] = 1'b1;
        cyc();
        acc_qready_i  = 1'b0;
        acc_pvalid_i  = 1'b1;
        acc_pdata_i   = rand_resp();
        core_pready_i = 4'b0111;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            eval();
            check_eq("t5_pready_low", 128'(acc_pready_o), 128'(0));
            check_eq("t5_pvalid_head", 128'(core_pvalid_o), 128'(4'b1000));
            advance();
        end
        core_pready_i = '1;
        @(negedge clk);
        eval();
        check_eq("t5_pready_high", 128'(acc_pready_o), 128'(1));
        advance();

        // Simultaneous push and pop at two outstanding; order preserved.
        core_qvalid_i = '0;
        do_reset();
        acc_qready_i     = 1'b1;
        core_pready_i    = '1;
        core_qvalid_i[0] = 1'b1;
        cyc();
        core_qvalid_i[1] = 1'b1;
        cyc();
        core_qvalid_i[2] = 1'b1;
        acc_pvalid_i     = 1'b1;
        acc_pdata_i      = rand_resp();
        @(negedge clk);
        eval();
        check_eq("t6_pvalid_first", 128'(core_pvalid_o), 128'(4'b0001));
        check_eq("t6_push_same_cycle", 128'(core_qready_o), 128'(4'b0100));
        advance();
        acc_qready_i = 1'b0;
        acc_pvalid_i = 1'b1;
        @(negedge clk);
        eval();
        check_eq("t6_pvalid_second", 128'(core_pvalid_o), 128'(4'b0010));
        advance();
        acc_pvalid_i = 1'b1;
        @(negedge clk);
        eval();
        check_eq("t6_pvalid_third", 128'(core_pvalid_o), 128'(4'b0100));
        advance();

        // Random traffic with a reset in the middle.
        core_qvalid_i = '0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!core_qvalid_i[i] && $urandom_range(0, 2) == 0) begin
                    core_qdata_i[i]  = rand_req();
                    core_qvalid_i[i] = 1'b1;
                end
            end
            acc_qready_i  = ($urandom_range(0, 3) != 0);
            core_pready_i = N'($urandom);
            if (!acc_pvalid_i && m_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                acc_pvalid_i = 1'b1;
                acc_pdata_i  = rand_resp();
            end
            if (c == 200) do_reset();
            else cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
